// File: rtl/fade_pkg.sv
// Shared types and segment-sequencing helpers for the HSV colour-wheel fader.
package fade_pkg;

  localparam int unsigned SEG_COUNT = 6;

  typedef enum logic [2:0] {
    S0_RG_UP = 3'd0,
    S1_RDN   = 3'd1,
    S2_BUP   = 3'd2,
    S3_GDN   = 3'd3,
    S4_RUP   = 3'd4,
    S5_BDN   = 3'd5
  } seg_t;

  function automatic seg_t seg_next(input seg_t s);
    return (s == S5_BDN) ? S0_RG_UP : seg_t'(3'(s) + 3'd1);
  endfunction

  function automatic seg_t seg_prev(input seg_t s);
    return (s == S0_RG_UP) ? S5_BDN : seg_t'(3'(s) - 3'd1);
  endfunction

  // Codes 6 and 7 are not segments; fold them onto S0.
  function automatic seg_t seg_from_bits(input logic [2:0] b);
    return (b >= 3'(SEG_COUNT)) ? S0_RG_UP : seg_t'(b);
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: duty latched at period end, registered compare against the shared counter.
module pwm_channel #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          period_end,
  input  logic [DW-1:0] count,
  input  logic [DW-1:0] duty,
  output logic          pin
);

  logic [DW-1:0] latched;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latched <= '0;
      pin     <= 1'b0;
    end else begin
      if (period_end) latched <= duty;
      pin <= (count < latched);
    end
  end

endmodule

// File: rtl/hsv_fade_pwm.sv
// HSV colour-wheel fader driving three PWM LED pins directly.
// Define FADE_BRIGHTNESS_EN to add an 8-bit brightness scaler on all duties.
module hsv_fade_pwm
  import fade_pkg::*;
#(
  parameter int unsigned PWM_INTERVAL  = 1200,
  parameter int unsigned TICK_INTERVAL = 12000,
  parameter int unsigned STEPS         = 200,
  localparam int unsigned DW           = $clog2(PWM_INTERVAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          dir,
  input  logic [1:0]    speed,
  input  logic          load,
  input  logic [2:0]    load_seg,
`ifdef FADE_BRIGHTNESS_EN
  input  logic [7:0]    brightness,
`endif
  output logic [DW-1:0] duty_r,
  output logic [DW-1:0] duty_g,
  output logic [DW-1:0] duty_b,
  output logic          pwm_r,
  output logic          pwm_g,
  output logic          pwm_b,
  output logic [2:0]    seg,
  output logic          wrap
);

  localparam int unsigned DUTY_MAX = PWM_INTERVAL - 1;
  localparam int unsigned STEP_VAL = DUTY_MAX / (STEPS - 1);
  localparam int unsigned PW       = $clog2(STEPS);
  localparam int unsigned TW       = $clog2(TICK_INTERVAL);
  localparam int unsigned MW       = DW + PW;
  localparam logic [PW-1:0] POS_LAST = PW'(STEPS - 1);
  localparam logic [DW-1:0] DMAX     = DW'(DUTY_MAX);

  seg_t          cur_seg;
  logic [PW-1:0] pos;
  logic [TW-1:0] tick_cnt;
  logic [TW-1:0] tick_lim;
  logic          tick;

  assign seg = cur_seg;

  // Ramp-step timer; >= lets a speed-up past the current count tick immediately.
  always_comb tick_lim = TW'((TICK_INTERVAL >> speed) - 1);
  assign tick = en && (tick_cnt >= tick_lim);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      tick_cnt <= '0;
    else if (load)   tick_cnt <= '0;
    else if (en)     tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
  end

  // Segment/position sequencer; load overrides a coincident tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_seg <= S0_RG_UP;
      pos     <= '0;
      wrap    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        cur_seg <= seg_from_bits(load_seg);
        pos     <= '0;
      end else if (tick) begin
        if (!dir) begin
          if (pos == POS_LAST) begin
            pos     <= '0;
            cur_seg <= seg_next(cur_seg);
            wrap    <= (cur_seg == S5_BDN);
          end else begin
            pos <= pos + PW'(1);
          end
        end else begin
          if (pos == '0) begin
            pos     <= POS_LAST;
            cur_seg <= seg_prev(cur_seg);
            wrap    <= (cur_seg == S0_RG_UP);
          end else begin
            pos <= pos - PW'(1);
          end
        end
      end
    end
  end

  logic [MW-1:0] prod;
  logic [DW-1:0] ramp;
  logic [DW-1:0] base_r, base_g, base_b;

  always_comb begin
    prod = MW'(pos) * MW'(STEP_VAL);
    if (pos == POS_LAST || prod > MW'(DUTY_MAX)) ramp = DMAX;
    else                                         ramp = DW'(prod);
  end

  always_comb begin
    base_r = '0;
    base_g = '0;
    base_b = '0;
    case (cur_seg)
      S0_RG_UP: begin base_r = DMAX;        base_g = ramp;        end
      S1_RDN:   begin base_r = DMAX - ramp; base_g = DMAX;        end
      S2_BUP:   begin base_g = DMAX;        base_b = ramp;        end
      S3_GDN:   begin base_g = DMAX - ramp; base_b = DMAX;        end
      S4_RUP:   begin base_r = ramp;        base_b = DMAX;        end
      S5_BDN:   begin base_r = DMAX;        base_b = DMAX - ramp; end
      default:  begin base_r = DMAX;                              end
    endcase
  end

`ifdef FADE_BRIGHTNESS_EN
  localparam int unsigned SW = DW + 9;
  logic [SW-1:0] sc_r, sc_g, sc_b;
  logic [8:0]    gain;

  always_comb begin
    gain   = 9'(brightness) + 9'd1;
    sc_r   = (SW'(base_r) * SW'(gain)) >> 8;
    sc_g   = (SW'(base_g) * SW'(gain)) >> 8;
    sc_b   = (SW'(base_b) * SW'(gain)) >> 8;
    duty_r = DW'(sc_r);
    duty_g = DW'(sc_g);
    duty_b = DW'(sc_b);
  end
`else
  assign duty_r = base_r;
  assign duty_g = base_g;
  assign duty_b = base_b;
`endif

  logic [DW-1:0] pwm_cnt;
  logic          period_end;

  assign period_end = (pwm_cnt == DMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= period_end ? '0 : pwm_cnt + DW'(1);
  end

  pwm_channel #(.DW(DW)) u_pwm_r (
    .clk(clk), .rst_n(rst_n), .period_end(period_end),
    .count(pwm_cnt), .duty(duty_r), .pin(pwm_r)
  );

  pwm_channel #(.DW(DW)) u_pwm_g (
    .clk(clk), .rst_n(rst_n), .period_end(period_end),
    .count(pwm_cnt), .duty(duty_g), .pin(pwm_g)
  );

  pwm_channel #(.DW(DW)) u_pwm_b (
    .clk(clk), .rst_n(rst_n), .period_end(period_end),
    .count(pwm_cnt), .duty(duty_b), .pin(pwm_b)
  );

endmodule

// File: tb/tb_hsv_fade_pwm.sv
// Bench for hsv_fade_pwm: wheel-phase reference model checked every cycle plus directed literal checks.
module tb_hsv_fade_pwm;

  localparam int PI    = 16;
  localparam int TI    = 8;
  localparam int ST    = 4;
  localparam int DMX   = 15;
  localparam int STEPV = 5;
  localparam int NPH   = 6 * ST;

  logic       clk = 1'b0;
  logic       rst_n, en, dir, load;
  logic [1:0] speed;
  logic [2:0] load_seg;
  logic [3:0] duty_r, duty_g, duty_b;
  logic       pwm_r, pwm_g, pwm_b;
  logic [2:0] seg;
  logic       wrap;

  hsv_fade_pwm #(.PWM_INTERVAL(PI), .TICK_INTERVAL(TI), .STEPS(ST)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .speed(speed),
    .load(load), .load_seg(load_seg),
    .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
    .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b),
    .seg(seg), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wraps;
  bit cmp_en;

  // Model state: absolute wheel phase 0..NPH-1 instead of segment/position.
  int m_phase, m_cnt, m_pc;
  int m_lat [3];
  bit m_pin [3];
  bit m_wrap;

  function automatic int ramp_of(input int p);
    if (p == ST - 1) return DMX;
    return (p * STEPV > DMX) ? DMX : p * STEPV;
  endfunction

  function automatic int exp_duty(input int phase, input int ch);
    int r;
    int rgb [3];
    r = ramp_of(phase % ST);
    case (phase / ST)
      0:       rgb = '{DMX, r, 0};
      1:       rgb = '{DMX - r, DMX, 0};
      2:       rgb = '{0, DMX, r};
      3:       rgb = '{0, DMX - r, DMX};
      4:       rgb = '{r, 0, DMX};
      default: rgb = '{DMX, 0, DMX - r};
    endcase
    return rgb[ch];
  endfunction

  function automatic bit tick_now();
    return en && (m_cnt >= (TI >> speed) - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_cnt   <= 0;
      m_wrap  <= 1'b0;
      m_pc    <= 0;
      for (int c = 0; c < 3; c++) begin
        m_lat[c] <= 0;
        m_pin[c] <= 1'b0;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        m_pin[c] <= (m_pc < m_lat[c]);
        if (m_pc == DMX) m_lat[c] <= exp_duty(m_phase, c);
      end
      m_pc   <= (m_pc + 1) % PI;
      m_wrap <= 1'b0;
      if (load) begin
        m_phase <= ((load_seg > 3'd5) ? 0 : int'(load_seg)) * ST;
        m_cnt   <= 0;
      end else begin
        if (en) m_cnt <= tick_now() ? 0 : m_cnt + 1;
        if (tick_now()) begin
          if (!dir) begin
            m_phase <= (m_phase + 1) % NPH;
            m_wrap  <= (m_phase == NPH - 1);
          end else begin
            m_phase <= (m_phase + NPH - 1) % NPH;
            m_wrap  <= (m_phase == 0);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("m_seg",    seg,    m_phase / ST);
      chk("m_duty_r", duty_r, exp_duty(m_phase, 0));
      chk("m_duty_g", duty_g, exp_duty(m_phase, 1));
      chk("m_duty_b", duty_b, exp_duty(m_phase, 2));
      chk("m_pwm_r",  pwm_r,  m_pin[0]);
      chk("m_pwm_g",  pwm_g,  m_pin[1]);
      chk("m_pwm_b",  pwm_b,  m_pin[2]);
      chk("m_wrap",   wrap,   m_wrap);
    end
  end

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      if (wrap === 1'b1) wraps++;
    end
  endtask

  task automatic count_high(input int n, output int hr, output int hg, output int hb);
    hr = 0; hg = 0; hb = 0;
    repeat (n) begin
      @(negedge clk);
      hr += int'(pwm_r);
      hg += int'(pwm_g);
      hb += int'(pwm_b);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int hr, hg, hb, i;
    rst_n = 1'b1; en = 1'b0; dir = 1'b0; load = 1'b0; speed = 2'd0; load_seg = 3'd0;
    cmp_en = 1'b0; wraps = 0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; cmp_en = 1'b1;

    // Move off reset state quickly, then reset asynchronously between edges.
    en = 1'b1; speed = 2'd3;
    run(20);
    chk("pre_reset_seg", seg, 5);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_seg", seg, 0);
    chk("rst_r", duty_r, 15);
    chk("rst_g", duty_g, 0);
    chk("rst_b", duty_b, 0);
    chk("rst_pins", {pwm_r, pwm_g, pwm_b}, 0);
    chk("rst_wrap", wrap, 0);
    @(negedge clk);
    en = 1'b0; speed = 2'd0; rst_n = 1'b1;
    @(negedge clk);

    // Forward ramp at speed 0: one step per 8 cycles.
    en = 1'b1; wraps = 0;
    chk("fw_g0", duty_g, 0);
    run(8); chk("fw_g1", duty_g, 5);
    run(8); chk("fw_g2", duty_g, 10);
    run(8); chk("fw_g3", duty_g, 15);
    run(8); chk("fw_seg1", seg, 1); chk("fw_s1_r", duty_r, 15);
    run(160);
    chk("fw_wrap_seg", seg, 0);
    chk("fw_wrap_now", wrap, 1);
    chk("fw_wrap_cnt", wraps, 1);

    // Reverse from S2 pos 2.
    run(80);
    chk("rv_seg2", seg, 2); chk("rv_b10", duty_b, 10);
    dir = 1'b1; wraps = 0;
    run(8); chk("rv_b5", duty_b, 5);
    run(8); chk("rv_b0", duty_b, 0);
    run(8); chk("rv_seg1", seg, 1); chk("rv_r0", duty_r, 0); chk("rv_g15", duty_g, 15);
    run(64);
    chk("rv_seg5", seg, 5); chk("rv_wrap", wrap, 1); chk("rv_wrap_cnt", wraps, 1);

    // Pause freezes everything but PWM.
    en = 1'b0;
    run(50);
    chk("pause_seg", seg, 5); chk("pause_r", duty_r, 15);
    chk("pause_b", duty_b, 0); chk("pause_wraps", wraps, 1);

    // Speed 3: tick every cycle.
    en = 1'b1; dir = 1'b0; speed = 2'd3; wraps = 0;
    run(1); chk("sp3_seg", seg, 0); chk("sp3_wrap", wrap, 1);
    run(3); chk("sp3_g15", duty_g, 15); chk("sp3_wraps", wraps, 1);

    // Speed-up with count already past the new limit ticks next cycle.
    speed = 2'd0;
    run(5); chk("spd_hold_seg", seg, 0);
    speed = 2'd2;
    run(1); chk("spd_tick_seg", seg, 1); chk("spd_tick_r", duty_r, 15);

    // Load coincident with a would-be reverse wrap tick.
    speed = 2'd0; dir = 1'b1; load = 1'b1; load_seg = 3'd0;
    run(1); load = 1'b0;
    run(7); chk("ld_pre_seg", seg, 0);
    load = 1'b1; load_seg = 3'd7; wraps = 0;
    run(1); load = 1'b0;
    chk("ld_seg", seg, 0); chk("ld_wrap", wrap, 0); chk("ld_r", duty_r, 15);
    run(7); chk("ld_hold_seg", seg, 0);
    run(1); chk("ld_next_seg", seg, 5); chk("ld_next_wrap", wrap, 1);

    // Load works while paused.
    en = 1'b0; load = 1'b1; load_seg = 3'd3;
    run(1); load = 1'b0;
    chk("ld_en0_seg", seg, 3); chk("ld_en0_b", duty_b, 15); chk("ld_en0_r", duty_r, 0);

    // PWM duty 15 / 0 high counts over a full period.
    load = 1'b1; load_seg = 3'd0;
    run(1); load = 1'b0;
    run(32);
    count_high(16, hr, hg, hb);
    chk("pwm_r_high", hr, 15); chk("pwm_g_high", hg, 0); chk("pwm_b_high", hb, 0);

    // Mid-period duty change waits for the next period.
    i = 0;
    while (m_pc != 7 && i < 20) begin @(negedge clk); i++; end
    chk("pc_align", m_pc, 7);
    load = 1'b1; load_seg = 3'd2;
    run(1); load = 1'b0;
    chk("mid_g_dmap", duty_g, 15);
    chk("mid_g_now", pwm_g, 0);
    count_high(8, hr, hg, hb);
    chk("mid_g_old", hg, 0);
    run(1);
    chk("mid_g_new", pwm_g, 1);

    run(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
